mips_mc_controller: RTL

Multicycle MIPS control unit: a Moore FSM plus ALU decoder that sequences each instruction through fetch, decode, execute, memory and write-back steps. It drives the enables and selects of the shared datapath: register file write enable, PC and IR enabled flops, and operand and result multiplexers. It supports a simple memory ready handshake so fetches and data accesses can stall.

---
 rtl/mips_mc_controller_if.sv | 35 +++
 rtl/mips_mc_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller side uses the master modport; the datapath side uses slave.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_write, ir_write, pc_en, reg_write, i_or_d,
               mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_write, ir_write, pc_en, reg_write, i_or_d,
               mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal_op
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder,
// with a memory ready handshake that stalls fetch and data accesses.
module mips_mc_controller (
    input  logic                        clk,
    input  logic                        reset,
    mips_mc_controller_if.master        ctrl_if
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
    } aluop_t;

    state_t state_q;
    state_t state_d;
    aluop_t aluOp;
    logic   pcWrite;
    logic   branch;
    logic   irWrite;
    logic   opLegal;

    assign opLegal = (ctrl_if.op == OP_RTYPE) || (ctrl_if.op == OP_LW)  ||
                     (ctrl_if.op == OP_SW)    || (ctrl_if.op == OP_BEQ) ||
                     (ctrl_if.op == OP_ADDI)  || (ctrl_if.op == OP_J);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:   if (ctrl_if.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (ctrl_if.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (ctrl_if.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (ctrl_if.mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (ctrl_if.mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of the datapath selects; unlisted outputs stay 0.
    always_comb begin
        ctrl_if.mem_req    = 1'b0;
        ctrl_if.mem_write  = 1'b0;
        ctrl_if.reg_write  = 1'b0;
        ctrl_if.i_or_d     = 1'b0;
        ctrl_if.mem_to_reg = 1'b0;
        ctrl_if.reg_dst    = 1'b0;
        ctrl_if.alu_src_a  = 1'b0;
        ctrl_if.alu_src_b  = 2'b00;
        ctrl_if.pc_src     = 2'b00;
        ctrl_if.illegal_op = 1'b0;
        aluOp              = ALUOP_ADD;
        pcWrite            = 1'b0;
        branch             = 1'b0;
        irWrite            = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ctrl_if.mem_req   = 1'b1;
                ctrl_if.alu_src_b = 2'b01;
                irWrite           = ctrl_if.mem_ready;
                pcWrite           = ctrl_if.mem_ready;
            end
            S_DECODE: begin
                ctrl_if.alu_src_b  = 2'b11;
                ctrl_if.illegal_op = ~opLegal;
            end
            S_MEMADR: begin
                ctrl_if.alu_src_a = 1'b1;
                ctrl_if.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl_if.mem_req = 1'b1;
                ctrl_if.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                ctrl_if.reg_write  = 1'b1;
                ctrl_if.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_if.mem_req   = 1'b1;
                ctrl_if.mem_write = 1'b1;
                ctrl_if.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_if.alu_src_a = 1'b1;
                aluOp             = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_if.reg_write = 1'b1;
                ctrl_if.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_if.alu_src_a = 1'b1;
                ctrl_if.pc_src    = 2'b01;
                aluOp             = ALUOP_SUB;
                branch            = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_if.alu_src_a = 1'b1;
                ctrl_if.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                ctrl_if.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_if.pc_src = 2'b10;
                pcWrite        = 1'b1;
            end
            default: begin
                aluOp = ALUOP_ADD;
            end
        endcase
    end

    // Flop enables are held off while reset is asserted so a ready memory
    // cannot load IR or PC during reset.
    assign ctrl_if.ir_write = irWrite & ~reset;
    assign ctrl_if.pc_en    = (pcWrite | (branch & ctrl_if.zero)) & ~reset;

    // Unknown funct codes fall back to add rather than trapping.
    always_comb begin
        ctrl_if.alu_control = 3'b010;
        unique case (aluOp)
            ALUOP_SUB: ctrl_if.alu_control = 3'b110;
            ALUOP_FUNCT: begin
                unique case (ctrl_if.funct)
                    6'b100010: ctrl_if.alu_control = 3'b110;
                    6'b100100: ctrl_if.alu_control = 3'b000;
                    6'b100101: ctrl_if.alu_control = 3'b001;
                    6'b101010: ctrl_if.alu_control = 3'b111;
                    default:   ctrl_if.alu_control = 3'b010;
                endcase
            end
            default: ctrl_if.alu_control = 3'b010;
        endcase
    end

endmodule
